// File: rtl/sprite_rasterizer.sv
// Frame-pass rasterizer: walks every object rectangle supplied by the object mux
// and emits one clipped VGA pixel write per clock in row-major order.
module sprite_rasterizer #(
    parameter int         NUM_OBJ   = 5,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         X_MAX     = 159,
    parameter int         Y_MAX     = 119
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic       erase,
    output logic [3:0] obj_sel,
    input  logic [7:0] start_x,
    input  logic [6:0] start_y,
    input  logic [4:0] width,
    input  logic [4:0] height,
    input  logic [2:0] color,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, LOAD, SCAN, NEXT, DONE} state_t;

    localparam logic [8:0] X_LIM    = 9'(X_MAX);
    localparam logic [7:0] Y_LIM    = 8'(Y_MAX);
    localparam logic [3:0] LAST_SEL = 4'(NUM_OBJ - 1);

    state_t     state, state_next;
    logic [3:0] obj_sel_next;
    logic       erase_q, erase_q_next;
    logic [7:0] sx, sx_next;
    logic [6:0] sy, sy_next;
    logic [4:0] w, w_next, h, h_next;
    logic [2:0] col, col_next;
    logic [4:0] dx, dx_next, dy, dy_next;
    logic [7:0] vga_x_next;
    logic [6:0] vga_y_next;
    logic [2:0] vga_colour_next;
    logic       plot_next, busy_next, done_next;

    logic       last_x, last_y;
    logic [4:0] scan_dx, scan_dy;
    logic [7:0] pix_bx;
    logic [6:0] pix_by;
    logic [4:0] pix_ox, pix_oy;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       visible;

    // The pixel registered at each edge is the one shown in the following cycle:
    // in LOAD it is (0,0) of the incoming rectangle, in SCAN the next scan position.
    assign last_x  = (dx == w - 5'd1);
    assign last_y  = (dy == h - 5'd1);
    assign scan_dx = last_x ? 5'd0 : dx + 5'd1;
    assign scan_dy = last_x ? dy + 5'd1 : dy;
    assign pix_bx  = (state == LOAD) ? start_x : sx;
    assign pix_by  = (state == LOAD) ? start_y : sy;
    assign pix_ox  = (state == LOAD) ? 5'd0 : scan_dx;
    assign pix_oy  = (state == LOAD) ? 5'd0 : scan_dy;
    assign sum_x   = {1'b0, pix_bx} + {4'b0000, pix_ox};
    assign sum_y   = {1'b0, pix_by} + {3'b000, pix_oy};
    assign visible = (sum_x <= X_LIM) && (sum_y <= Y_LIM);

    always_comb begin
        state_next      = state;
        obj_sel_next    = obj_sel;
        erase_q_next    = erase_q;
        sx_next         = sx;
        sy_next         = sy;
        w_next          = w;
        h_next          = h;
        col_next        = col;
        dx_next         = dx;
        dy_next         = dy;
        vga_x_next      = vga_x;
        vga_y_next      = vga_y;
        vga_colour_next = vga_colour;
        plot_next       = 1'b0;
        busy_next       = busy;
        done_next       = 1'b0;

        case (state)
            IDLE: begin
                if (go) begin
                    erase_q_next = erase;
                    obj_sel_next = 4'd0;
                    busy_next    = 1'b1;
                    state_next   = LOAD;
                end
            end
            LOAD: begin
                sx_next  = start_x;
                sy_next  = start_y;
                w_next   = width;
                h_next   = height;
                col_next = erase_q ? BG_COLOUR : color;
                dx_next  = 5'd0;
                dy_next  = 5'd0;
                if (width == 5'd0 || height == 5'd0) begin
                    state_next = NEXT;
                end else begin
                    state_next      = SCAN;
                    vga_x_next      = sum_x[7:0];
                    vga_y_next      = sum_y[6:0];
                    vga_colour_next = erase_q ? BG_COLOUR : color;
                    plot_next       = visible;
                end
            end
            SCAN: begin
                if (last_x && last_y) begin
                    state_next = NEXT;
                end else begin
                    dx_next    = scan_dx;
                    dy_next    = scan_dy;
                    vga_x_next = sum_x[7:0];
                    vga_y_next = sum_y[6:0];
                    plot_next  = visible;
                end
            end
            NEXT: begin
                if (obj_sel == LAST_SEL) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    obj_sel_next = obj_sel + 4'd1;
                    state_next   = LOAD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            obj_sel    <= 4'd0;
            erase_q    <= 1'b0;
            sx         <= 8'd0;
            sy         <= 7'd0;
            w          <= 5'd0;
            h          <= 5'd0;
            col        <= 3'd0;
            dx         <= 5'd0;
            dy         <= 5'd0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            obj_sel    <= obj_sel_next;
            erase_q    <= erase_q_next;
            sx         <= sx_next;
            sy         <= sy_next;
            w          <= w_next;
            h          <= h_next;
            col        <= col_next;
            dx         <= dx_next;
            dy         <= dy_next;
            vga_x      <= vga_x_next;
            vga_y      <= vga_y_next;
            vga_colour <= vga_colour_next;
            plot       <= plot_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

endmodule

// File: tb/tb_sprite_rasterizer.sv
// Scoreboard bench for sprite_rasterizer: a behavioural object mux feeds rectangles,
// expected pixels are queued per pass and popped whenever plot is seen.
module tb_sprite_rasterizer;

    logic       clk;
    logic       resetn;
    logic       go;
    logic       erase;
    logic [3:0] obj_sel;
    logic [7:0] start_x;
    logic [6:0] start_y;
    logic [4:0] width;
    logic [4:0] height;
    logic [2:0] color;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    logic [7:0] ox [16];
    logic [6:0] oy [16];
    logic [4:0] ow [16];
    logic [4:0] oh [16];
    logic [2:0] oc [16];

    logic [17:0] exp_q [$];
    int compared = 0;
    int mismatched = 0;

    sprite_rasterizer dut (
        .clk        (clk),
        .resetn     (resetn),
        .go         (go),
        .erase      (erase),
        .obj_sel    (obj_sel),
        .start_x    (start_x),
        .start_y    (start_y),
        .width      (width),
        .height     (height),
        .color      (color),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        start_x = ox[obj_sel];
        start_y = oy[obj_sel];
        width   = ow[obj_sel];
        height  = oh[obj_sel];
        color   = oc[obj_sel];
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Every plotted pixel must be the next one the reference model predicted.
    always @(negedge clk) begin
        if (resetn && plot) begin
            if (exp_q.size() == 0) begin
                check_output("plot_extra", 32'(plot), 32'd0);
            end else begin
                check_output("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic clear_objs();
        for (int i = 0; i < 16; i++) begin
            ox[i] = 8'd0; oy[i] = 7'd0; ow[i] = 5'd0; oh[i] = 5'd0; oc[i] = 3'd0;
        end
    endtask

    task automatic set_obj(input int i, input int x, input int y, input int w, input int h, input logic [2:0] c);
        ox[i] = 8'(x); oy[i] = 7'(y); ow[i] = 5'(w); oh[i] = 5'(h); oc[i] = c;
    endtask

    task automatic push_pass(input bit er);
        int px, py;
        logic [7:0] bx;
        logic [6:0] by;
        for (int o = 0; o < 5; o++) begin
            for (int dy = 0; dy < int'(oh[o]); dy++) begin
                for (int dx = 0; dx < int'(ow[o]); dx++) begin
                    px = int'(ox[o]) + dx;
                    py = int'(oy[o]) + dy;
                    if (px <= 159 && py <= 119) begin
                        bx = px[7:0];
                        by = py[6:0];
                        exp_q.push_back({bx, by, er ? 3'b000 : oc[o]});
                    end
                end
            end
        end
    endtask

    function automatic int pass_len();
        int n = 1;
        for (int o = 0; o < 5; o++) n += 2 + int'(ow[o]) * int'(oh[o]);
        return n;
    endfunction

    task automatic applyStimulus(input bit er, input bit noise, input string tag);
        int exp_len;
        int k;
        bit done_seen;
        exp_len = pass_len();
        push_pass(er);
        @(negedge clk);
        go = 1'b1;
        erase = er;
        k = 0;
        done_seen = 0;
        while (!done_seen && k < exp_len + 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check_output({tag, "_busy_first"}, 32'(busy), 32'd1);
                check_output({tag, "_sel_first"}, 32'(obj_sel), 32'd0);
            end
            go = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) erase = 1'($urandom_range(0, 1));
            if (done) begin
                done_seen = 1;
                go = 1'b0;
            end
        end
        check_output({tag, "_done_cycle"}, 32'(k), 32'(exp_len));
        check_output({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check_output({tag, "_sel_at_done"}, 32'(obj_sel), 32'd4);
        check_output({tag, "_pixels_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        check_output({tag, "_idle_done"}, 32'(done), 32'd0);
        check_output({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int len;
        int k;
        int first_done;
        int n_done;

        resetn = 1'b0;
        go = 1'b0;
        erase = 1'b0;
        clear_objs();
        repeat (2) @(negedge clk);
        check_output("rst_obj_sel", 32'(obj_sel), 32'd0);
        check_output("rst_vga_xyc", 32'({vga_x, vga_y, vga_colour}), 32'd0);
        check_output("rst_plot", 32'(plot), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        set_obj(0, 10, 20, 2, 2, 3'b010);
        applyStimulus(1'b0, 1'b0, "single");
        applyStimulus(1'b1, 1'b0, "erase");

        clear_objs();
        set_obj(0, 158, 118, 4, 4, 3'b111);
        applyStimulus(1'b0, 1'b0, "clip");

        clear_objs();
        set_obj(0, 0, 0, 8, 8, 3'b001);
        set_obj(1, 20, 10, 6, 6, 3'b010);
        set_obj(2, 40, 30, 6, 6, 3'b011);
        set_obj(3, 60, 50, 6, 6, 3'b100);
        set_obj(4, 150, 110, 6, 6, 3'b110);
        applyStimulus(1'b0, 1'b1, "all5");

        // Back-to-back passes with go held high: second done lands at 2*len+1.
        clear_objs();
        set_obj(0, 10, 20, 2, 2, 3'b010);
        len = pass_len();
        push_pass(1'b0);
        push_pass(1'b0);
        @(negedge clk);
        go = 1'b1;
        erase = 1'b0;
        k = 0;
        n_done = 0;
        first_done = 0;
        while (n_done < 2 && k < 2 * len + 20) begin
            @(negedge clk);
            k++;
            if (done) begin
                n_done++;
                if (n_done == 1) first_done = k;
            end
        end
        go = 1'b0;
        check_output("b2b_first_done", 32'(first_done), 32'(len));
        check_output("b2b_second_done", 32'(k), 32'(2 * len + 1));
        check_output("b2b_pixels_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);

        // Asynchronous reset during the fifth pixel of a 4x3 object.
        clear_objs();
        set_obj(0, 10, 20, 4, 3, 3'b101);
        push_pass(1'b0);
        @(negedge clk);
        go = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            go = 1'b0;
        end
        check_output("mid_plot_before", 32'(plot), 32'd1);
        #1 resetn = 1'b0;
        #1;
        check_output("mid_rst_plot", 32'(plot), 32'd0);
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check_output("post_rst_busy", 32'(busy), 32'd0);
        check_output("post_rst_sel", 32'(obj_sel), 32'd0);
        check_output("post_rst_plot", 32'(plot), 32'd0);

        set_obj(0, 10, 20, 2, 2, 3'b010);
        set_obj(0, 10, 20, 2, 2, 3'b010);
        applyStimulus(1'b0, 1'b0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
